// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx
// Brief    : PS/2 device-to-host frame receiver (sync, deglitch, deserialize).
//            Optional parity check enabled by defining PS2_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]            clk_s_q, data_s_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  fclk_q, fclk_d;
  logic                  fall_q, bit_q;

  state_t      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [15:0] tocnt_q, tocnt_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic        par_ok;

  always_comb begin
    fclk_d = fclk_q;
    if (&filt_q)       fclk_d = 1'b1;
    else if (~|filt_q) fclk_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s_q  <= 2'b11;
      data_s_q <= 2'b11;
      filt_q   <= '1;
      fclk_q   <= 1'b1;
      fall_q   <= 1'b0;
      bit_q    <= 1'b1;
    end else begin
      clk_s_q  <= {clk_s_q[0], ps2_clk};
      data_s_q <= {data_s_q[0], ps2_data};
      filt_q   <= {filt_q[FILTER_LEN-2:0], clk_s_q[1]};
      fclk_q   <= fclk_d;
      fall_q   <= fclk_q & ~fclk_d;
      bit_q    <= data_s_q[1];
    end
  end

`ifdef PS2_RX_PARITY_EN
  logic par_q, par_d;
  assign par_ok = ^{par_q, shreg_q};

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    tocnt_d   = 16'd0;
    rx_data_d = rx_data_q;
    rdy_d     = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_RX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (fall_q && !bit_q) begin
          state_d  = DATA;
          bitcnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall_q) begin
          shreg_d  = {bit_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_q) begin
`ifdef PS2_RX_PARITY_EN
          par_d   = bit_q;
`endif
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall_q) begin
          state_d = IDLE;
          if (bit_q && par_ok) begin
            rx_data_d = shreg_q;
            rdy_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeout only applies mid-frame and yields to a completing edge.
    if (state_q != IDLE && !fall_q) begin
      if (tocnt_q == TO_LAST) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        tocnt_d = tocnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bitcnt_q  <= 3'd0;
      shreg_q   <= 8'h00;
      tocnt_q   <= 16'd0;
      rx_data_q <= 8'h00;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      tocnt_q   <= tocnt_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_rdy  = rdy_q;
  assign rx_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx
// Brief    : Scoreboard bench for ps2_rx; directed PS/2 frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 5000;
  localparam int HALF           = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_err;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] last_good;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .rx_err  (rx_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: every output strobe must match the next expected event.
  always @(negedge clk) begin
    if (rx_rdy || rx_err) begin
      ev_t e;
      n_chk++;
      if (rx_rdy && rx_err) begin
        n_fail++;
        $display("FAIL both_strobes: rdy=%0b err=%0b, required never both", rx_rdy, rx_err);
      end
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: rdy=%0b err=%0b data=%02h, required no event",
                 rx_rdy, rx_err, rx_data);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err != rx_err || rx_data != e.data) begin
          n_fail++;
          $display("FAIL event: err=%0b data=%02h, required err=%0b data=%02h",
                   rx_err, rx_data, e.is_err, e.data);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  task automatic push_ev(input logic is_err, input logic [7:0] d);
    exp_q.push_back('{is_err: is_err, data: d});
  endtask

  // Drive frame bits [first..last]; data changes while the clock is high.
  // par_flip inverts the correct odd-parity bit; glitch_bit gets a 4-cycle low pulse.
  task automatic send_bits(input logic [7:0] d, input logic par_flip, input logic stop,
                           input int half, input int first, input int last, input int glitch_bit);
    logic [10:0] fr;
    fr = {stop, (~^d) ^ par_flip, d, 1'b0};
    for (int i = first; i <= last; i++) begin
      ps2_data = fr[i];
      if (i == glitch_bit) begin
        wait_cyc(half / 4);
        ps2_clk = 1'b0;
        wait_cyc(4);
        ps2_clk = 1'b1;
        wait_cyc(half - half / 4 - 4);
      end else begin
        wait_cyc(half);
      end
      ps2_clk = 1'b0;
      wait_cyc(half);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop, input int half);
    send_bits(d, par_flip, stop, half, 0, 10, -1);
    wait_cyc(50);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rx_data"}, rx_data, 8'h00);
    chk({tag, "_rx_rdy"}, {7'd0, rx_rdy}, 8'h00);
    chk({tag, "_rx_err"}, {7'd0, rx_err}, 8'h00);
  endtask

  initial begin
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst      = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(2);
    chk_outputs_zero("reset");
    last_good = 8'h00;
    wait_cyc(20);

    // 0x1C, slow 3000-cycle bit period
    push_ev(1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1500);
    last_good = 8'h1C;
    chk("hold_1C", rx_data, 8'h1C);

    // 0x5A with inverted parity
`ifdef PS2_RX_PARITY_EN
    push_ev(1'b1, last_good);
`else
    push_ev(1'b0, 8'h5A);
    last_good = 8'h5A;
`endif
    send_frame(8'h5A, 1'b1, 1'b1, HALF);
    chk("after_bad_parity", rx_data, last_good);

    // 0xF0 with stop bit 0, then a clean 0xF0
    push_ev(1'b1, last_good);
    send_frame(8'hF0, 1'b0, 1'b0, HALF);
    chk("after_bad_stop", rx_data, last_good);
    push_ev(1'b0, 8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, HALF);
    last_good = 8'hF0;

    // glitch in IDLE, then glitch inside a frame
    ps2_clk = 1'b0;
    wait_cyc(4);
    ps2_clk = 1'b1;
    wait_cyc(50);
    chk("idle_glitch_queue", 8'(exp_q.size()), 8'd0);
    push_ev(1'b0, 8'h12);
    send_bits(8'h12, 1'b0, 1'b1, HALF, 0, 10, 4);
    wait_cyc(50);
    last_good = 8'h12;

    // abort after start + 3 bits; expect a single timeout error
    push_ev(1'b1, last_good);
    send_bits(8'h55, 1'b0, 1'b1, HALF, 0, 3, -1);
    wait_cyc(TIMEOUT_CYCLES + 10);
    chk("timeout_consumed", 8'(exp_q.size()), 8'd0);
    push_ev(1'b0, 8'hAA);
    send_frame(8'hAA, 1'b0, 1'b1, HALF);
    last_good = 8'hAA;

    // reset after bit 5; remaining bits are all ones so nothing restarts
    send_bits(8'hFF, 1'b0, 1'b1, HALF, 0, 5, -1);
    wait_cyc(10);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(1);
    chk_outputs_zero("midreset");
    send_bits(8'hFF, 1'b0, 1'b1, HALF, 6, 10, -1);
    wait_cyc(TIMEOUT_CYCLES / 4);
    chk("midreset_quiet", 8'(exp_q.size()), 8'd0);
    push_ev(1'b0, 8'h29);
    send_frame(8'h29, 1'b0, 1'b1, HALF);
    chk("final_data", rx_data, 8'h29);

    wait_cyc(200);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
